// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller
// Description : Alarm-clock sequencer with IDLE/RINGING/SNOOZE states, ring
//               timeout and a bounded number of snoozes per alarm event.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_controller #(
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned MAX_SNOOZE       = 3
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_on,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       siren_enb,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] snooze_used
);

    localparam logic [9:0] RING_LAST = 10'(RING_TIMEOUT_SEC - 1);
    localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_SEC);
    localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] ring_cnt_q, ring_cnt_d;
    logic [9:0] snz_cnt_q, snz_cnt_d;
    logic [2:0] snooze_used_q, snooze_used_d;
    logic       ringing_q, snoozing_q;
    logic       match;

    // Seconds==0 qualification limits triggering to once per alarm minute.
    assign match = tick_1hz & alarm_on & (cur_hour == alarm_hour) &
                   (cur_min == alarm_min) & (cur_sec == 6'd0);

    always_comb begin
        state_d       = state_q;
        ring_cnt_d    = ring_cnt_q;
        snz_cnt_d     = snz_cnt_q;
        snooze_used_d = snooze_used_q;
        if (!alarm_on) begin
            state_d       = IDLE;
            ring_cnt_d    = 10'd0;
            snz_cnt_d     = 10'd0;
            snooze_used_d = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match) begin
                        state_d       = RINGING;
                        ring_cnt_d    = 10'd0;
                        snooze_used_d = 3'd0;
                    end
                end
                RINGING: begin
                    // Priority: stop, then timeout, then snooze, then counting.
                    if (stop_btn || (tick_1hz && ring_cnt_q == RING_LAST)) begin
                        state_d       = IDLE;
                        ring_cnt_d    = 10'd0;
                        snooze_used_d = 3'd0;
                    end else if (snooze_btn && snooze_used_q < SNZ_MAX) begin
                        state_d       = SNOOZE;
                        ring_cnt_d    = 10'd0;
                        snz_cnt_d     = SNZ_LOAD;
                        snooze_used_d = snooze_used_q + 3'd1;
                    end else if (tick_1hz) begin
                        ring_cnt_d = ring_cnt_q + 10'd1;
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_d       = IDLE;
                        snz_cnt_d     = 10'd0;
                        snooze_used_d = 3'd0;
                    end else if (tick_1hz) begin
                        if (snz_cnt_q <= 10'd1) begin
                            state_d    = RINGING;
                            ring_cnt_d = 10'd0;
                            snz_cnt_d  = 10'd0;
                        end else begin
                            snz_cnt_d = snz_cnt_q - 10'd1;
                        end
                    end
                end
                default: begin
                    state_d       = IDLE;
                    ring_cnt_d    = 10'd0;
                    snz_cnt_d     = 10'd0;
                    snooze_used_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q       <= IDLE;
            ring_cnt_q    <= 10'd0;
            snz_cnt_q     <= 10'd0;
            snooze_used_q <= 3'd0;
            ringing_q     <= 1'b0;
            snoozing_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ring_cnt_q    <= ring_cnt_d;
            snz_cnt_q     <= snz_cnt_d;
            snooze_used_q <= snooze_used_d;
            ringing_q     <= (state_d == RINGING);
            snoozing_q    <= (state_d == SNOOZE);
        end
    end

    assign siren_enb   = ringing_q;
    assign ringing     = ringing_q;
    assign snoozing    = snoozing_q;
    assign snooze_used = snooze_used_q;

endmodule
`default_nettype wire
